// File: rtl/led_fade_driver.sv
// LED fade driver: turns the blinker's on/off level into linear PWM brightness ramps.
// Optional LED_FADE_GAMMA_EN adds a registered square-law brightness map ahead of the PWM compare.
module led_fade_driver #(
  parameter int unsigned PWM_BITS         = 8,
  parameter int unsigned MAX_LEVEL        = 255,
  parameter int unsigned RAMP_STEP_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int unsigned PreW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [PreW-1:0]     PreLast  = PreW'(RAMP_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LevelMax = PWM_BITS'(MAX_LEVEL);
  // PWM period is 2^PWM_BITS-1 so that the top level drives a constant 1.
  localparam logic [PWM_BITS-1:0] CntLast  = ~PWM_BITS'(1);

  typedef enum logic [1:0] {StIdleOff, StRampUp, StIdleOn, StRampDown} state_e;

  state_e              state_q, state_d;
  logic                s1_q, led_s_q;
  logic [PreW-1:0]     pre_q, pre_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_q;
  logic                step;

  assign step = (pre_q == PreLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      led_s_q <= 1'b0;
      state_q <= StIdleOff;
      pre_q   <= '0;
      level_q <= '0;
    end else begin
      s1_q    <= led_in;
      led_s_q <= s1_q;
      state_q <= state_d;
      pre_q   <= pre_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    level_d = level_q;
    unique case (state_q)
      StIdleOff: begin
        if (led_s_q) begin
          state_d = StRampUp;
          pre_d   = '0;
        end
      end
      StRampUp: begin
        if (!led_s_q) begin
          state_d = StRampDown;
          pre_d   = '0;
        end else if (step) begin
          pre_d   = '0;
          level_d = level_q + 1'b1;
          if (level_d == LevelMax) state_d = StIdleOn;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      StIdleOn: begin
        if (!led_s_q) begin
          state_d = StRampDown;
          pre_d   = '0;
        end
      end
      StRampDown: begin
        if (level_q == '0) begin
          state_d = StIdleOff;
        end else if (led_s_q) begin
          state_d = StRampUp;
          pre_d   = '0;
        end else if (step) begin
          pre_d   = '0;
          level_d = level_q - 1'b1;
          if (level_d == '0) state_d = StIdleOff;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = StIdleOff;
    endcase
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  logic [PWM_BITS-1:0]   duty_q;

  // level*(level+1) >> PWM_BITS maps 0 -> 0 and full scale -> full scale exactly.
  assign sq = {{PWM_BITS{1'b0}}, level_q} * ({{PWM_BITS{1'b0}}, level_q} + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) duty_q <= '0;
    else     duty_q <= PWM_BITS'(sq >> PWM_BITS);
  end

  assign duty = duty_q;
`else
  assign duty = level_q;
`endif

  // The PWM counter free-runs across state changes so ramps never restart the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      pwm_q <= (duty > cnt_q);
    end
  end

  assign pwm_out = pwm_q;
  assign level   = level_q;
  assign busy    = (state_q == StRampUp) || (state_q == StRampDown);

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: expected {busy, level} change events are queued by the
// stimulus and checked by a monitor whenever the DUT's busy/level outputs change.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led_in = 1'b1;
  logic       led_b = 1'b1;
  logic       pwm_a, busy_a, pwm_b, busy_b;
  logic [3:0] level_a, level_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         c;
    logic       b;
    logic [3:0] l;
  } exp_t;

  exp_t q[$];

`ifdef LED_FADE_GAMMA_EN
  localparam int ExpHighsB = 12;
`else
  localparam int ExpHighsB = 20;
`endif

  led_fade_driver #(
    .PWM_BITS        (4),
    .MAX_LEVEL       (15),
    .RAMP_STEP_CYCLES(2)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .led_in (led_in),
    .pwm_out(pwm_a),
    .level  (level_a),
    .busy   (busy_a)
  );

  led_fade_driver #(
    .PWM_BITS        (4),
    .MAX_LEVEL       (10),
    .RAMP_STEP_CYCLES(2)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .led_in (led_b),
    .pwm_out(pwm_b),
    .level  (level_b),
    .busy   (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic b, input logic [3:0] l);
    exp_t e;
    e.c = c;
    e.b = b;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d events pending, expected 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: any change of {busy, level} is an output event to be matched in order.
  initial begin : monitor
    logic [4:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en && ({busy_a, level_a} !== prev)) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL mon_unexpected at cyc %0d: got busy=%0b level=%0d, expected no change",
                   cyc, busy_a, level_a);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.b !== busy_a || e.l !== level_a) begin
            n_bad++;
            $display("FAIL mon_event: got cyc=%0d busy=%0b level=%0d, expected cyc=%0d busy=%0b level=%0d",
                     cyc, busy_a, level_a, e.c, e.b, e.l);
          end
        end
      end
      prev = {busy_a, level_a};
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    int highs;

    // Reset held three edges with led_in already high.
    repeat (3) begin
      @(negedge clk);
      check("rst_pwm", pwm_a, 0);
      check("rst_level", level_a, 0);
      check("rst_busy", busy_a, 0);
    end

    // Full ramp up: busy 3 edges after release, one level per 2 edges, IDLE_ON at level 15.
    c = cyc;
    rst = 1'b0;
    mon_en = 1'b1;
    push(c + 3, 1'b1, 4'd0);
    for (int k = 1; k <= 14; k++) push(c + 3 + 2 * k, 1'b1, 4'(k));
    push(c + 33, 1'b0, 4'd15);
    drain("ramp_up");

    repeat (2) @(negedge clk);
    repeat (15) begin
      @(negedge clk);
      check("pwm_full_on", pwm_a, 1);
    end

    // MAX_LEVEL=10 instance sits in IDLE_ON with a 10/15 duty cycle.
    check("b_level", level_b, 10);
    check("b_busy", busy_b, 0);
    highs = 0;
    repeat (30) begin
      @(negedge clk);
      highs += int'(pwm_b);
    end
    check("b_duty_highs", highs, ExpHighsB);

    // Full ramp down from 15 to 0.
    @(negedge clk);
    c = cyc;
    led_in = 1'b0;
    push(c + 3, 1'b1, 4'd15);
    for (int k = 1; k <= 14; k++) push(c + 3 + 2 * k, 1'b1, 4'(15 - k));
    push(c + 33, 1'b0, 4'd0);
    drain("ramp_down");

    // Reversal at level 7: no jump, 7 -> 6 two edges after RAMP_DOWN entry.
    @(negedge clk);
    c = cyc;
    led_in = 1'b1;
    push(c + 3, 1'b1, 4'd0);
    for (int k = 1; k <= 7; k++) push(c + 3 + 2 * k, 1'b1, 4'(k));
    repeat (16) @(negedge clk);
    led_in = 1'b0;
    for (int k = 1; k <= 6; k++) push(c + 19 + 2 * k, 1'b1, 4'(7 - k));
    push(c + 33, 1'b0, 4'd0);
    drain("reversal");

    // One-cycle pulse: busy for exactly RAMP_UP + RAMP_DOWN, level and pwm stay 0.
    @(negedge clk);
    c = cyc;
    led_in = 1'b1;
    push(c + 3, 1'b1, 4'd0);
    push(c + 5, 1'b0, 4'd0);
    @(negedge clk);
    led_in = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("pulse_pwm", pwm_a, 0);
    end
    drain("pulse");
    check("pulse_level", level_a, 0);

    // Reset mid-ramp takes priority.
    mon_en = 1'b0;
    led_in = 1'b1;
    repeat (12) @(negedge clk);
    check("midramp_level", level_a, 4);
    check("midramp_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_level", level_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_pwm", pwm_a, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
